// File: rtl/conv2_maxpool_relu_pkg.sv
// Shared types and helpers for the conv-2 max-pool/ReLU stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv2_maxpool_relu_pkg;

  // Pooling FSM: four reads per 2x2 window, a capture slot for the last
  // read's data, one write slot, and a finish state that pulses done.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_CAP,
    ST_WR,
    ST_FIN
  } pool_state_t;

  // Width of the conv result memory select.
  localparam int CH_SEL_WIDTH = 3;

  // Widest data word the signed-max helper can carry.
  localparam int MAX_DATA_WIDTH = 64;

  // Pooled map width: floor, so an odd last column is dropped.
  function automatic int pool_width(input int w);
    return w / 2;
  endfunction

  // Pooled map height: floor, so an odd last row is dropped.
  function automatic int pool_height(input int h);
    return h / 2;
  endfunction

  // Signed maximum; on a tie the first operand is kept.
  function automatic logic signed [MAX_DATA_WIDTH-1:0] smax(
    input logic signed [MAX_DATA_WIDTH-1:0] a,
    input logic signed [MAX_DATA_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/conv2_maxpool_relu_if.sv
// Bus bundle between the pooling stage and its host: start/busy/done control,
// conv result read port (1-cycle read latency) and pool buffer write port.
// Backpressure: none; the host memories accept a read/write every cycle.
interface conv2_maxpool_relu_if
  import conv2_maxpool_relu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                    start;
  logic [CH_SEL_WIDTH-1:0] rd_channel;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    busy;
  logic                    done;

  // Host side: issues start, returns read data, sinks writes.
  modport master (
    output start,
    output rd_data,
    input  rd_channel,
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  busy,
    input  done
  );

  // Pooling block side.
  modport slave (
    input  start,
    input  rd_data,
    output rd_channel,
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    output busy,
    output done
  );

endinterface

// File: rtl/conv2_maxpool_relu_pool_window_addr_gen.sv
// Window walker: pc/pr/ch counters, read base and pool-buffer write address.
// Latency: addresses are combinational from the counters; counters step on advance_i.
// Backpressure: none; the caller decides when to advance.
module pool_window_addr_gen
  import conv2_maxpool_relu_pkg::*;
#(
  parameter int CONV_RESULT_WIDTH  = 10,
  parameter int CONV_RESULT_HEIGHT = 10,
  parameter int CHANNEL_NUM        = 2,
  parameter int ADDR_WIDTH         = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    advance_i,
  output logic [CH_SEL_WIDTH-1:0] ch_o,
  output logic [ADDR_WIDTH-1:0]   rd_base_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic                    last_o
);

  localparam int PW = pool_width(CONV_RESULT_WIDTH);
  localparam int PH = pool_height(CONV_RESULT_HEIGHT);

  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   pr_q;
  logic [CH_SEL_WIDTH-1:0] ch_q;

  logic pc_last;
  logic pr_last;
  logic ch_last;

  assign pc_last = (pc_q == ADDR_WIDTH'(PW - 1));
  assign pr_last = (pr_q == ADDR_WIDTH'(PH - 1));
  assign ch_last = (ch_q == CH_SEL_WIDTH'(CHANNEL_NUM - 1));
  assign last_o  = pc_last && pr_last && ch_last;

  // Top-left of the window is (2*pr, 2*pc) in the conv map.
  assign rd_base_o = ADDR_WIDTH'(2 * CONV_RESULT_WIDTH) * pr_q
                   + {pc_q[ADDR_WIDTH-2:0], 1'b0};

  // Channel-major pooled layout.
  assign wr_addr_o = ADDR_WIDTH'(PW * PH) * ADDR_WIDTH'(ch_q)
                   + ADDR_WIDTH'(PW) * pr_q
                   + pc_q;

  assign ch_o = ch_q;

  // Column counter wraps into row, row wraps into channel; after the final
  // window every counter is back at zero, ready for the next start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q <= '0;
      pr_q <= '0;
      ch_q <= '0;
    end else if (clear_i) begin
      pc_q <= '0;
      pr_q <= '0;
      ch_q <= '0;
    end else if (advance_i) begin
      if (pc_last) begin
        pc_q <= '0;
        if (pr_last) begin
          pr_q <= '0;
          ch_q <= ch_last ? '0 : ch_q + CH_SEL_WIDTH'(1);
        end else begin
          pr_q <= pr_q + ADDR_WIDTH'(1);
        end
      end else begin
        pc_q <= pc_q + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/conv2_maxpool_relu.sv
// 2x2 stride-2 max pool + ReLU over CHANNEL_NUM conv-2 result maps into the pool buffer.
// Latency: 6 cycles per window; start->done = 6*CHANNEL_NUM*PW*PH + 2 cycles.
// Backpressure: none; start is ignored while busy or while done is high.
module conv2_maxpool_relu
  import conv2_maxpool_relu_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int FRACTION_WIDTH     = 16,
  parameter int ADDR_WIDTH         = 10,
  parameter int CONV_RESULT_WIDTH  = 10,
  parameter int CONV_RESULT_HEIGHT = 10,
  parameter int CHANNEL_NUM        = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  conv2_maxpool_relu_if.slave bus
);

  localparam int PW = pool_width(CONV_RESULT_WIDTH);
  localparam int PH = pool_height(CONV_RESULT_HEIGHT);

  // Fixed-point format passes through untouched: max and ReLU never rescale,
  // so FRACTION_WIDTH only has to describe a legal format.
  if (CONV_RESULT_WIDTH < 2 || CONV_RESULT_HEIGHT < 2 ||
      CHANNEL_NUM < 1 || CHANNEL_NUM > 8 ||
      CHANNEL_NUM * PW * PH > 2 ** ADDR_WIDTH ||
      CONV_RESULT_WIDTH * CONV_RESULT_HEIGHT > 2 ** ADDR_WIDTH ||
      DATA_WIDTH < 2 || DATA_WIDTH > MAX_DATA_WIDTH ||
      FRACTION_WIDTH < 0 || FRACTION_WIDTH >= DATA_WIDTH) begin : g_bad_params
    $error("conv2_maxpool_relu: illegal parameter combination");
  end

  pool_state_t             state_q;
  logic [CH_SEL_WIDTH-1:0] rd_channel_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   max_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    wr_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    last_q;

  logic                    start_accept;
  logic                    advance;
  logic [CH_SEL_WIDTH-1:0] gen_ch;
  logic [ADDR_WIDTH-1:0]   gen_rd_base;
  logic [ADDR_WIDTH-1:0]   gen_wr_addr;
  logic                    gen_last;
  logic [DATA_WIDTH-1:0]   max_nxt;
  logic [DATA_WIDTH-1:0]   relu_nxt;

  // A start coinciding with the done pulse belongs to the finished run.
  assign start_accept = (state_q == ST_IDLE) && bus.start && !done_q;

  // Counters step once the window's write address has been captured, so by
  // the WR slot they already point at the next window.
  assign advance = (state_q == ST_CAP);

  pool_window_addr_gen #(
    .CONV_RESULT_WIDTH  (CONV_RESULT_WIDTH),
    .CONV_RESULT_HEIGHT (CONV_RESULT_HEIGHT),
    .CHANNEL_NUM        (CHANNEL_NUM),
    .ADDR_WIDTH         (ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (start_accept),
    .advance_i (advance),
    .ch_o      (gen_ch),
    .rd_base_o (gen_rd_base),
    .wr_addr_o (gen_wr_addr),
    .last_o    (gen_last)
  );

  // Running signed max against the word arriving this cycle, and its ReLU.
  always_comb begin
    max_nxt  = DATA_WIDTH'(smax(MAX_DATA_WIDTH'(signed'(max_q)),
                                MAX_DATA_WIDTH'(signed'(bus.rd_data))));
    relu_nxt = max_nxt[DATA_WIDTH-1] ? '0 : max_nxt;
  end

  // Window sequencer. Addresses are loaded on entry to each read state so
  // the data for the address of state RDn arrives in the following state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      rd_channel_q <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      max_q        <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Counters are zero in IDLE (reset or wrapped), so the base is window 0.
          if (start_accept) begin
            state_q      <= ST_RD0;
            busy_q       <= 1'b1;
            rd_addr_q    <= gen_rd_base;
            rd_channel_q <= gen_ch;
          end
        end
        ST_RD0: begin
          state_q   <= ST_RD1;
          rd_addr_q <= gen_rd_base + ADDR_WIDTH'(1);
        end
        ST_RD1: begin
          state_q   <= ST_RD2;
          rd_addr_q <= gen_rd_base + ADDR_WIDTH'(CONV_RESULT_WIDTH);
          max_q     <= bus.rd_data;
        end
        ST_RD2: begin
          state_q   <= ST_RD3;
          rd_addr_q <= gen_rd_base + ADDR_WIDTH'(CONV_RESULT_WIDTH + 1);
          max_q     <= max_nxt;
        end
        ST_RD3: begin
          state_q <= ST_CAP;
          max_q   <= max_nxt;
        end
        ST_CAP: begin
          state_q   <= ST_WR;
          max_q     <= max_nxt;
          wr_en_q   <= 1'b1;
          wr_data_q <= relu_nxt;
          wr_addr_q <= gen_wr_addr;
          last_q    <= gen_last;
        end
        ST_WR: begin
          if (last_q) begin
            state_q <= ST_FIN;
          end else begin
            state_q      <= ST_RD0;
            rd_addr_q    <= gen_rd_base;
            rd_channel_q <= gen_ch;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_channel = rd_channel_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
